// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register-select response path.
//   rggen_status_e          : response status returned to the host
//   rggen_collector_state_e : transaction state of rggen_response_collector
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RESPOND = 2'b10
  } rggen_collector_state_e;

endpackage

// File: rtl/rggen_response_collector_or_reducer.sv
// rggen_or_reducer: combinational OR of N masked WIDTH-bit slices.
//   i_data   : N packed slices, slice k at [k*WIDTH +: WIDTH]
//   i_mask   : per-slice enable
//   o_result : OR of every slice whose mask bit is set (0 when none)
module rggen_or_reducer #(
  parameter int WIDTH = 1,
  parameter int N     = 1
) (
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [N-1:0]       i_mask,
  output logic [WIDTH-1:0]   o_result
);

  always_comb begin
    o_result = '0;
    for (int k = 0; k < N; k++) begin
      if (i_mask[k]) begin
        o_result = o_result | i_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_response_collector.sv
// rggen_response_collector: host-side end of the register-select path.
// Accepts one command at a time, strobes the single selected register,
// waits (bounded) for its ready, and returns a status plus read data.
//   clk, rst_n             : clock, asynchronous active-low reset
//   i_command_valid/write  : host command request and direction
//   o_command_ready        : high while idle
//   o_response_valid/ready : response handshake
//   o_response_status      : OKAY / SLAVE_ERROR (timeout) / DECODE_ERROR
//   o_response_read_data   : captured read data (0 for writes and errors)
//   o_register_valid       : access strobe, high for every BUSY cycle
//   i_register_select      : per-register address match
//   i_register_ready       : per-register access done
//   i_register_read_data   : packed read data, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
module rggen_response_collector
  import rggen_rtl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_command_valid,
  input  logic                                  i_command_write,
  output logic                                  o_command_ready,
  output logic                                  o_response_valid,
  input  logic                                  i_response_ready,
  output logic [1:0]                            o_response_status,
  output logic [DATA_WIDTH-1:0]                 o_response_read_data,
  output logic                                  o_register_valid,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_select,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_ready,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  rggen_collector_state_e   state;
  rggen_collector_state_e   state_next;
  logic [CNT_W-1:0]         counter;
  logic [CNT_W-1:0]         counter_next;
  rggen_status_e            status;
  rggen_status_e            status_next;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [DATA_WIDTH-1:0]    read_data_next;

  logic [TOTAL_REGISTERS-1:0] hit_mask;
  logic                       hit_any;
  logic [DATA_WIDTH-1:0]      hit_read_data;

  // Exactly one decoder match is required; zero or several is a decode error.
  function automatic logic is_one_hot(input logic [TOTAL_REGISTERS-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < TOTAL_REGISTERS; k++) begin
      if (v[k]) n++;
    end
    return (n == 1);
  endfunction

  // Ready from a register that is not selected must never complete the access.
  assign hit_mask = i_register_select & i_register_ready;

  rggen_or_reducer #(
    .WIDTH (1),
    .N     (TOTAL_REGISTERS)
  ) u_hit_reducer (
    .i_data   (i_register_select),
    .i_mask   (i_register_ready),
    .o_result (hit_any)
  );

  rggen_or_reducer #(
    .WIDTH (DATA_WIDTH),
    .N     (TOTAL_REGISTERS)
  ) u_read_data_reducer (
    .i_data   (i_register_read_data),
    .i_mask   (hit_mask),
    .o_result (hit_read_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      status    <= RGGEN_OKAY;
      read_data <= '0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      status    <= status_next;
      read_data <= read_data_next;
    end
  end

  always_comb begin
    state_next     = state;
    counter_next   = counter;
    status_next    = status;
    read_data_next = read_data;
    case (state)
      IDLE: begin
        if (i_command_valid) begin
          if (is_one_hot(i_register_select)) begin
            state_next   = BUSY;
            counter_next = '0;
          end else begin
            state_next     = RESPOND;
            status_next    = RGGEN_DECODE_ERROR;
            read_data_next = '0;
          end
        end
      end
      BUSY: begin
        // A ready arriving on the timeout cycle still counts as success.
        if (hit_any) begin
          state_next     = RESPOND;
          status_next    = RGGEN_OKAY;
          read_data_next = i_command_write ? '0 : hit_read_data;
        end else if (counter == LAST_COUNT) begin
          state_next     = RESPOND;
          status_next    = RGGEN_SLAVE_ERROR;
          read_data_next = '0;
        end else begin
          counter_next = counter + CNT_W'(1);
        end
      end
      RESPOND: begin
        if (i_response_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All outputs are decoded straight from flops, so reset reaches them
  // asynchronously.
  assign o_command_ready      = (state == IDLE);
  assign o_register_valid     = (state == BUSY);
  assign o_response_valid     = (state == RESPOND);
  assign o_response_status    = status;
  assign o_response_read_data = read_data;

endmodule

// File: tb/tb_rggen_response_collector.sv
module tb_rggen_response_collector;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk;
  logic            rst_n;
  logic            i_command_valid;
  logic            i_command_write;
  logic            o_command_ready;
  logic            o_response_valid;
  logic            i_response_ready;
  logic [1:0]      o_response_status;
  logic [DW-1:0]   o_response_read_data;
  logic            o_register_valid;
  logic [NR-1:0]   i_register_select;
  logic [NR-1:0]   i_register_ready;
  logic [NR*DW-1:0] i_register_read_data;

  logic [DW-1:0] slot_data [NR];

  int checks;
  int errors;

  rggen_response_collector #(
    .DATA_WIDTH      (DW),
    .TOTAL_REGISTERS (NR),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_command_valid      (i_command_valid),
    .i_command_write      (i_command_write),
    .o_command_ready      (o_command_ready),
    .o_response_valid     (o_response_valid),
    .i_response_ready     (i_response_ready),
    .o_response_status    (o_response_status),
    .o_response_read_data (o_response_read_data),
    .o_register_valid     (o_register_valid),
    .i_register_select    (i_register_select),
    .i_register_ready     (i_register_ready),
    .i_register_read_data (i_register_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: from the command and the ready schedule, work
  // out how long the strobe lasts, when the response appears and what it
  // carries, then compare the DUT cycle by cycle against that timeline.
  // Called at posedge+1; cycle 0 is the acceptance cycle.
  task automatic run_txn(input string tag, input logic [NR-1:0] sel, input logic wr,
                         input int ready_at, input int ready_len, input int ready_slot,
                         input int hold,
                         output int lat, output int strobes,
                         output logic [1:0] st, output logic [DW-1:0] rd);
    int exp_strobe, exp_resp, last;
    logic [1:0] exp_st;
    logic [DW-1:0] exp_rd;
    logic sel_hit;
    lat = -1; strobes = 0; st = 2'bxx; rd = 'x;
    sel_hit = (ready_at > 0) && sel[ready_slot] && (ready_at <= TO);
    if ($countones(sel) != 1) begin
      exp_strobe = 0; exp_resp = 1; exp_st = 2'b11; exp_rd = '0;
    end else if (sel_hit) begin
      exp_strobe = ready_at; exp_resp = ready_at + 1; exp_st = 2'b00;
      exp_rd = wr ? '0 : slot_data[ready_slot];
    end else begin
      exp_strobe = TO; exp_resp = TO + 1; exp_st = 2'b10; exp_rd = '0;
    end
    last = exp_resp + hold + 1;
    for (int c = 0; c <= last; c++) begin
      i_command_valid   = (c == 0);
      i_command_write   = wr;
      i_register_select = sel;
      i_register_ready  = (ready_at > 0 && c >= ready_at && c < ready_at + ready_len)
                          ? NR'(1 << ready_slot) : '0;
      i_response_ready  = (c == exp_resp + hold);
      @(negedge clk);
      chk($sformatf("%s c%0d register_valid", tag, c), o_register_valid,
          (c >= 1 && c <= exp_strobe));
      chk($sformatf("%s c%0d response_valid", tag, c), o_response_valid,
          (c >= exp_resp && c <= exp_resp + hold));
      chk($sformatf("%s c%0d command_ready", tag, c), o_command_ready,
          (c == 0 || c == last));
      if (c >= exp_resp && c <= exp_resp + hold) begin
        chk($sformatf("%s c%0d status", tag, c), o_response_status, exp_st);
        chk($sformatf("%s c%0d read_data", tag, c), o_response_read_data, exp_rd);
      end
      if (o_register_valid) strobes++;
      if (o_response_valid && lat < 0) begin
        lat = c; st = o_response_status; rd = o_response_read_data;
      end
      @(posedge clk);
      #1;
    end
    i_command_valid  = 1'b0;
    i_register_ready = '0;
    i_response_ready = 1'b0;
  endtask

  int lat, strobes;
  logic [1:0] st;
  logic [DW-1:0] rd;

  initial begin
    checks = 0;
    errors = 0;
    slot_data[0] = 32'hA5A5_0001;
    slot_data[1] = 32'h0BAD_F00D;
    slot_data[2] = 32'hDEAD_BEEF;
    slot_data[3] = 32'h1234_5678;
    i_register_read_data = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};
    rst_n = 1'b0;
    i_command_valid = 1'b0;
    i_command_write = 1'b0;
    i_response_ready = 1'b0;
    i_register_select = '0;
    i_register_ready = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset register_valid", o_register_valid, 1'b0);
    chk("reset response_valid", o_response_valid, 1'b0);
    chk("reset status", o_response_status, 2'b00);
    chk("reset read_data", o_response_read_data, '0);
    chk("reset command_ready", o_command_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Read, ready in first BUSY cycle.
    run_txn("rd_first", 4'b0100, 1'b0, 1, 1, 2, 0, lat, strobes, st, rd);
    chk("rd_first latency", lat, 2);
    chk("rd_first strobes", strobes, 1);
    chk("rd_first status", st, 2'b00);
    chk("rd_first data", rd, 32'hDEADBEEF);

    // No hit and two hits: decode error, no strobe.
    run_txn("dec_none", 4'b0000, 1'b0, 0, 0, 0, 0, lat, strobes, st, rd);
    chk("dec_none latency", lat, 1);
    chk("dec_none strobes", strobes, 0);
    chk("dec_none status", st, 2'b11);
    chk("dec_none data", rd, 0);
    run_txn("dec_multi", 4'b0110, 1'b0, 1, 2, 1, 1, lat, strobes, st, rd);
    chk("dec_multi latency", lat, 1);
    chk("dec_multi strobes", strobes, 0);
    chk("dec_multi status", st, 2'b11);

    // Timeout, then ready on the last allowed BUSY cycle.
    run_txn("timeout", 4'b0001, 1'b0, 0, 0, 0, 0, lat, strobes, st, rd);
    chk("timeout latency", lat, 17);
    chk("timeout strobes", strobes, 16);
    chk("timeout status", st, 2'b10);
    chk("timeout data", rd, 0);
    run_txn("late_ready", 4'b0001, 1'b0, 16, 1, 0, 0, lat, strobes, st, rd);
    chk("late_ready latency", lat, 17);
    chk("late_ready strobes", strobes, 16);
    chk("late_ready status", st, 2'b00);
    chk("late_ready data", rd, 32'hA5A50001);

    // Write with backpressured response.
    run_txn("write", 4'b1000, 1'b1, 3, 1, 3, 5, lat, strobes, st, rd);
    chk("write latency", lat, 4);
    chk("write strobes", strobes, 3);
    chk("write status", st, 2'b00);
    chk("write data", rd, 0);

    // Ready from a non-selected slot is ignored.
    run_txn("foreign_ready", 4'b0001, 1'b0, 1, 20, 1, 0, lat, strobes, st, rd);
    chk("foreign_ready latency", lat, 17);
    chk("foreign_ready status", st, 2'b10);

    // Reset asserted mid-BUSY.
    i_command_valid = 1'b1;
    i_command_write = 1'b0;
    i_register_select = 4'b0001;
    @(posedge clk);
    #1 i_command_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset register_valid", o_register_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset register_valid", o_register_valid, 1'b0);
    chk("async_reset response_valid", o_response_valid, 1'b0);
    chk("async_reset command_ready", o_command_ready, 1'b1);
    chk("async_reset status", o_response_status, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    i_register_select = '0;
    @(negedge clk);
    chk("post_reset command_ready", o_command_ready, 1'b1);
    chk("post_reset register_valid", o_register_valid, 1'b0);
    @(posedge clk);
    #1;
    run_txn("after_reset", 4'b0100, 1'b0, 2, 1, 2, 0, lat, strobes, st, rd);
    chk("after_reset latency", lat, 3);
    chk("after_reset strobes", strobes, 2);
    chk("after_reset status", st, 2'b00);
    chk("after_reset data", rd, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
